// File: rtl/dmi_arbiter.sv
// Two-master round-robin arbiter in front of a single DMI port, one transaction in flight.
// Define DMI_ARBITER_TIMEOUT_EN to build in the response watchdog (TIMEOUT_CYCLES).
// Request layout {addr[6:0], op[1:0], data[31:0]}; response layout {data[31:0], resp[1:0]}.
// Handshakes: a beat moves on a rising edge where valid and ready are both high; valid never waits on ready.
module dmi_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [40:0] m0_req_i,
    input  logic        m0_valid_i,
    output logic        m0_ready_o,
    output logic [33:0] m0_resp_o,
    output logic        m0_resp_valid_o,
    input  logic        m0_resp_ready_i,
    input  logic [40:0] m1_req_i,
    input  logic        m1_valid_i,
    output logic        m1_ready_o,
    output logic [33:0] m1_resp_o,
    output logic        m1_resp_valid_o,
    input  logic        m1_resp_ready_i,
    output logic [40:0] dmi_req_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    input  logic [33:0] dmi_resp_i,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    output logic        busy_o,
    output logic        owner_o,
    output logic [1:0]  state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] ST_DELIV = 2'd3;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("dmi_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

    logic [1:0]  r_state;
    logic [40:0] r_req;
    logic [33:0] r_resp;
    logic        r_owner;
    logic        r_last;
    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_owner_ack;
    logic        w_wdog_expire;

    assign w_idle = (r_state == ST_IDLE) && !rst_i;

    // r_last holds the previous grantee; on contention the other master wins.
    assign w_grant0 = w_idle && m0_valid_i && (!m1_valid_i || r_last);
    assign w_grant1 = w_idle && m1_valid_i && (!m0_valid_i || !r_last);

    assign w_owner_ack = r_owner ? m1_resp_ready_i : m0_resp_ready_i;

`ifdef DMI_ARBITER_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wdog;

    // A real response in the expiry cycle wins over the synthetic failure.
    assign w_wdog_expire = (r_state == ST_RESP) && !dmi_resp_valid_i && (r_wdog == WDOG_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wdog <= 16'd0;
        end else if (r_state == ST_REQ && dmi_req_ready_i) begin
            r_wdog <= 16'd0;
        end else if (r_state == ST_RESP) begin
            r_wdog <= r_wdog + 16'd1;
        end
    end
`else
    assign w_wdog_expire = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_req   <= '0;
            r_resp  <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_req   <= w_grant1 ? m1_req_i : m0_req_i;
                        r_owner <= w_grant1;
                        r_last  <= w_grant1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmi_req_ready_i) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (dmi_resp_valid_i) begin
                        r_resp  <= dmi_resp_i;
                        r_state <= ST_DELIV;
                    end else if (w_wdog_expire) begin
                        r_resp  <= {32'h0, 2'h2};
                        r_state <= ST_DELIV;
                    end
                end
                ST_DELIV: begin
                    if (w_owner_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m0_ready_o       = w_grant0;
    assign m1_ready_o       = w_grant1;
    assign dmi_req_o        = r_req;
    assign dmi_req_valid_o  = (r_state == ST_REQ);
    // Responses landing in IDLE are strays: accepted and dropped.
    assign dmi_resp_ready_o = !rst_i && (r_state == ST_IDLE || r_state == ST_RESP);
    assign m0_resp_o        = r_resp;
    assign m1_resp_o        = r_resp;
    assign m0_resp_valid_o  = (r_state == ST_DELIV) && !r_owner;
    assign m1_resp_valid_o  = (r_state == ST_DELIV) && r_owner;
    assign busy_o           = (r_state != ST_IDLE);
    assign owner_o          = r_owner;
    assign state_o          = r_state;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Self-checking bench for dmi_arbiter: vector table, directed corner sequences, random traffic vs transaction model.
// Define DMI_ARBITER_TIMEOUT_EN on both files to exercise the watchdog (TIMEOUT_CYCLES = 8).
module tb_dmi_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [40:0] m0_req, m1_req;
    logic        m0_valid, m1_valid, m0_ready, m1_ready;
    logic [33:0] m0_resp, m1_resp;
    logic        m0_resp_valid, m1_resp_valid, m0_resp_ready, m1_resp_ready;
    logic [40:0] dmi_req;
    logic        dmi_req_valid, dmi_req_ready;
    logic [33:0] dmi_resp;
    logic        dmi_resp_valid, dmi_resp_ready;
    logic        busy, owner;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        v0;
        logic        v1;
        logic        hold;
        logic [40:0] q0;
        logic [40:0] q1;
        logic [33:0] dresp;
        int          exp_owner;
    } vec_t;

    vec_t vecs[8];

    // Random-phase transaction model state.
    logic [40:0] exp_q[$];
    logic [33:0] exp_resp_q[$];
    logic        pend0, pend1, mbusy, mlast, mowner, allow_new;
    logic        ds_has, exp_grant, set_busy, clr_busy;
    logic [33:0] ds_data;
    int          ds_wait, n_done;

    always #5 clk = ~clk;

    dmi_arbiter #(.TIMEOUT_CYCLES(TMO)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_valid_i(m0_valid), .m0_ready_o(m0_ready),
        .m0_resp_o(m0_resp), .m0_resp_valid_o(m0_resp_valid), .m0_resp_ready_i(m0_resp_ready),
        .m1_req_i(m1_req), .m1_valid_i(m1_valid), .m1_ready_o(m1_ready),
        .m1_resp_o(m1_resp), .m1_resp_valid_o(m1_resp_valid), .m1_resp_ready_i(m1_resp_ready),
        .dmi_req_o(dmi_req), .dmi_req_valid_o(dmi_req_valid), .dmi_req_ready_i(dmi_req_ready),
        .dmi_resp_i(dmi_resp), .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(dmi_resp_ready),
        .busy_o(busy), .owner_o(owner), .state_o(state)
    );

    function automatic logic [40:0] mk_req(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
        return {a, op, d};
    endfunction

    function automatic logic [33:0] mk_resp(input logic [31:0] d, input logic [1:0] r);
        return {d, r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        m0_req = '0; m1_req = '0; m0_valid = 0; m1_valid = 0;
        m0_resp_ready = 0; m1_resp_ready = 0;
        dmi_req_ready = 0; dmi_resp = '0; dmi_resp_valid = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_owner"}, owner, 0);
        check({tag, "_rdy"}, {m0_ready, m1_ready, dmi_resp_ready}, 0);
        check({tag, "_vld"}, {m0_resp_valid, m1_resp_valid, dmi_req_valid}, 0);
        check({tag, "_req_reg"}, dmi_req, 0);
        check({tag, "_resp_reg"}, {m0_resp, m1_resp}, 0);
    endtask

    // One transaction with all downstream/response readies high; downstream answers the cycle after req handshake.
    task automatic run_txn(input logic v0, input logic v1, input logic hold,
                           input logic [40:0] q0, input logic [40:0] q1, input logic [33:0] dresp,
                           output int got_owner, output int lat,
                           output logic [40:0] got_req, output logic [33:0] got_resp,
                           output logic bad_ready, output logic bad_valid);
        logic pend;
        got_owner = -1; lat = -1; got_req = '0; got_resp = '0;
        bad_ready = 0; bad_valid = 0; pend = 0;
        m0_req = q0; m1_req = q1; m0_valid = v0; m1_valid = v1;
        dmi_req_ready = 1; m0_resp_ready = 1; m1_resp_ready = 1;
        dmi_resp_valid = 0; dmi_resp = '0;
        for (int c = 0; c < 8 && got_owner < 0; c++) begin
            #1;
            if (m0_ready && m1_ready) bad_ready = 1;
            if (m0_ready) got_owner = 0;
            else if (m1_ready) got_owner = 1;
            tick();
        end
        if (!hold) begin
            m0_valid = 0; m1_valid = 0;
        end
        if (got_owner >= 0) begin
            for (int c = 1; c <= 40 && lat < 0; c++) begin
                dmi_resp_valid = pend;
                dmi_resp = pend ? dresp : '0;
                #1;
                if (m0_ready || m1_ready) bad_ready = 1;
                if (dmi_resp_valid && dmi_resp_ready) pend = 0;
                if (dmi_req_valid && dmi_req_ready) begin
                    got_req = dmi_req;
                    pend = 1;
                end
                if ((got_owner == 0 && m1_resp_valid) || (got_owner == 1 && m0_resp_valid)) bad_valid = 1;
                if (m0_resp_valid || m1_resp_valid) begin
                    lat = c;
                    got_resp = m1_resp_valid ? m1_resp : m0_resp;
                end
                tick();
            end
        end
        dmi_resp_valid = 0;
    endtask

    task automatic txn_and_check(input string tag, input vec_t v);
        int          got_owner, lat;
        logic [40:0] got_req;
        logic [33:0] got_resp;
        logic        bad_ready, bad_valid;
        run_txn(v.v0, v.v1, v.hold, v.q0, v.q1, v.dresp, got_owner, lat, got_req, got_resp, bad_ready, bad_valid);
        check({tag, "_grant"}, 64'(got_owner), 64'(v.exp_owner));
        check({tag, "_owner_o"}, owner, 64'(v.exp_owner));
        check({tag, "_dmi_req"}, got_req, (v.exp_owner == 1) ? v.q1 : v.q0);
        check({tag, "_resp"}, got_resp, v.dresp);
        check({tag, "_latency"}, 64'(lat), 3);
        check({tag, "_ready_rule"}, bad_ready, 0);
        check({tag, "_nonowner_valid"}, bad_valid, 0);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        int          lat;
        logic        flag;
        logic [40:0] q;
        logic [33:0] r;

        // ---------------- reset state ----------------
        drive_idle();
        rst = 1;
        m0_valid = 1;
        tick();
        tick();
        check_reset_outputs("reset");
        check("reset_state", state, 0);
        m0_valid = 0;
        rst = 0;
        #1;
        check("post_reset_resp_ready", dmi_resp_ready, 1);
        tick();

        // ---------------- vector table ----------------
        vecs[0] = '{1, 1, 1, mk_req(7'h01, 2'd1, 32'h0), mk_req(7'h02, 2'd1, 32'h0), mk_resp(32'hA0A0A0A0, 2'd0), 0};
        vecs[1] = '{1, 1, 1, mk_req(7'h03, 2'd2, 32'h11112222), mk_req(7'h04, 2'd2, 32'h33334444), mk_resp(32'hA1A1A1A1, 2'd0), 1};
        vecs[2] = '{1, 1, 1, mk_req(7'h05, 2'd1, 32'h0), mk_req(7'h06, 2'd1, 32'h0), mk_resp(32'hA2A2A2A2, 2'd3), 0};
        vecs[3] = '{1, 1, 1, mk_req(7'h07, 2'd2, 32'h55556666), mk_req(7'h08, 2'd2, 32'h77778888), mk_resp(32'hA3A3A3A3, 2'd0), 1};
        vecs[4] = '{1, 0, 0, mk_req(7'h11, 2'd1, 32'h0), mk_req(7'h7F, 2'd3, 32'hFFFFFFFF), mk_resp(32'hDEADBEEF, 2'd0), 0};
        vecs[5] = '{0, 1, 0, mk_req(7'h12, 2'd1, 32'h0), mk_req(7'h13, 2'd2, 32'h01234567), mk_resp(32'h89ABCDEF, 2'd0), 1};
        vecs[6] = '{1, 0, 0, mk_req(7'h7F, 2'd2, 32'hFFFFFFFF), mk_req(7'h00, 2'd0, 32'h0), mk_resp(32'hFFFFFFFF, 2'd3), 0};
        vecs[7] = '{1, 1, 0, mk_req(7'h21, 2'd1, 32'h0), mk_req(7'h22, 2'd1, 32'h0), mk_resp(32'h00000001, 2'd0), 1};
        for (int i = 0; i < 8; i++) begin
            txn_and_check($sformatf("vec%0d", i), vecs[i]);
        end

        // ---------------- back-pressure on m1 ----------------
        q = mk_req(7'h2A, 2'd2, 32'hCAFE0001);
        r = mk_resp(32'h0BADF00D, 2'd0);
        drive_idle();
        m1_req = q; m1_valid = 1;
        #1;
        check("bp_grant", m1_ready, 1);
        tick();
        m1_valid = 0;
        m0_valid = 1;
        m0_req = mk_req(7'h55, 2'd1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_req_valid", dmi_req_valid, 1);
            check("bp_req_stable", dmi_req, q);
            check("bp_m_ready", {m0_ready, m1_ready}, 0);
            check("bp_busy", busy, 1);
            check("bp_resp_ready_req", dmi_resp_ready, 0);
            tick();
        end
        dmi_req_ready = 1;
        tick();
        dmi_req_ready = 0;
        m0_valid = 0;
        dmi_resp_valid = 1;
        dmi_resp = r;
        #1;
        check("bp_resp_ready_resp", dmi_resp_ready, 1);
        tick();
        dmi_resp_valid = 0;
        dmi_resp = mk_resp(32'h12345678, 2'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_m1_resp_valid", m1_resp_valid, 1);
            check("bp_m1_resp_stable", m1_resp, r);
            check("bp_m0_resp", {m0_resp_valid, m0_resp}, {1'b0, r});
            check("bp_deliv_busy", busy, 1);
            check("bp_resp_ready_deliv", dmi_resp_ready, 0);
            tick();
        end
        m1_resp_ready = 1;
        tick();
        check("bp_done_busy", {busy, m1_resp_valid, owner}, 3'b001);

        // ---------------- reset in RESP, stray response afterwards ----------------
        drive_idle();
        m1_req = mk_req(7'h33, 2'd1, 32'h0);
        m1_valid = 1;
        dmi_req_ready = 1;
        tick();
        m1_valid = 0;
        tick();
        check("rr_in_resp", state, 2);
        rst = 1;
        tick();
        check_reset_outputs("rr");
        rst = 0;
        dmi_resp_valid = 1;
        dmi_resp = mk_resp(32'h5555AAAA, 2'd0);
        #1;
        check("rr_stray_ready", dmi_resp_ready, 1);
        tick();
        dmi_resp_valid = 0;
        flag = 0;
        for (int i = 0; i < 3; i++) begin
            if (m0_resp_valid || m1_resp_valid || busy || m0_resp != 0) flag = 1;
            tick();
        end
        check("rr_stray_dropped", flag, 0);
        txn_and_check("rr_next", '{1, 1, 0, mk_req(7'h44, 2'd1, 32'h0), mk_req(7'h45, 2'd1, 32'h0),
                                   mk_resp(32'hC0FFEE00, 2'd0), 0});

`ifdef DMI_ARBITER_TIMEOUT_EN
        // ---------------- watchdog expiry, late response is a stray ----------------
        drive_idle();
        m0_req = mk_req(7'h66, 2'd1, 32'h0);
        m0_valid = 1; dmi_req_ready = 1; m0_resp_ready = 1;
        #1;
        check("to_grant", m0_ready, 1);
        tick();
        m0_valid = 0;
        lat = -1;
        r = '0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            if (m0_resp_valid) begin
                lat = c;
                r = m0_resp;
            end
            tick();
        end
        check("to_latency", 64'(lat), 64'(2 + TMO));
        check("to_resp", r, mk_resp(32'h0, 2'h2));
        for (int c = lat + 1; c < 20; c++) tick();
        dmi_resp_valid = 1;
        dmi_resp = mk_resp(32'h00001234, 2'd0);
        #1;
        check("to_late_ready", dmi_resp_ready, 1);
        tick();
        dmi_resp_valid = 0;
        #1;
        check("to_late_dropped", {busy, m0_resp_valid, m1_resp_valid, m0_resp}, {3'b000, mk_resp(32'h0, 2'h2)});
        tick();
`else
        // ---------------- no watchdog: RESP waits indefinitely ----------------
        drive_idle();
        m0_req = mk_req(7'h66, 2'd1, 32'h0);
        m0_valid = 1; dmi_req_ready = 1; m0_resp_ready = 1;
        tick();
        m0_valid = 0;
        tick();
        flag = 0;
        for (int i = 0; i < 30; i++) begin
            if (state != 2 || !busy || m0_resp_valid || m1_resp_valid) flag = 1;
            tick();
        end
        check("wait_resp_held", flag, 0);
        dmi_resp_valid = 1;
        dmi_resp = mk_resp(32'h00001234, 2'd0);
        tick();
        dmi_resp_valid = 0;
        check("wait_resp_deliv", {m0_resp_valid, m0_resp}, {1'b1, mk_resp(32'h00001234, 2'd0)});
        tick();
`endif

        // ---------------- random traffic vs transaction model ----------------
        do_reset();
        pend0 = 0; pend1 = 0; mbusy = 0; mlast = 1; mowner = 0;
        ds_has = 0; ds_wait = 0; ds_data = '0; n_done = 0; allow_new = 1;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            if (cyc == 1200) allow_new = 0;
            if (!allow_new && !mbusy && !pend0 && !pend1) break;
            if (allow_new && !pend0 && $urandom_range(0, 3) == 0) begin
                pend0 = 1;
                m0_req = {9'($urandom_range(0, 511)), $urandom};
            end
            if (allow_new && !pend1 && $urandom_range(0, 3) == 0) begin
                pend1 = 1;
                m1_req = {9'($urandom_range(0, 511)), $urandom};
            end
            m0_valid = pend0;
            m1_valid = pend1;
            dmi_req_ready = ($urandom_range(0, 2) != 0);
            m0_resp_ready = 1'($urandom_range(0, 1));
            m1_resp_ready = 1'($urandom_range(0, 1));
            dmi_resp_valid = ds_has && (ds_wait == 0);
            dmi_resp = dmi_resp_valid ? ds_data : '0;
            #1;
            set_busy = 0;
            clr_busy = 0;
            exp_grant = (pend0 && pend1) ? !mlast : pend1;
            check("rand_busy", busy, mbusy);
            check("rand_owner", owner, mowner);
            if (mbusy || !(pend0 || pend1)) begin
                check("rand_ready_low", {m1_ready, m0_ready}, 0);
            end else begin
                check("rand_grant", {m1_ready, m0_ready}, exp_grant ? 2'b10 : 2'b01);
                exp_q.push_back(exp_grant ? m1_req : m0_req);
                if (exp_grant) pend1 = 0;
                else pend0 = 0;
                mowner = exp_grant;
                mlast = exp_grant;
                set_busy = 1;
            end
            if (dmi_req_valid && dmi_req_ready) begin
                check("rand_req_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) check("rand_dmi_req", dmi_req, exp_q.pop_front());
                ds_has = 1;
                ds_wait = $urandom_range(0, 4);
                ds_data = {$urandom, 2'($urandom_range(0, 3))};
            end else if (dmi_resp_valid && dmi_resp_ready) begin
                exp_resp_q.push_back(dmi_resp);
                ds_has = 0;
            end else if (ds_has && !dmi_resp_valid && ds_wait > 0) begin
                ds_wait--;
            end
            if (m0_resp_valid || m1_resp_valid) begin
                check("rand_resp_to_owner", {m1_resp_valid, m0_resp_valid}, mowner ? 2'b10 : 2'b01);
                check("rand_resp_pending", exp_resp_q.size(), 1);
                if ((m0_resp_valid && m0_resp_ready) || (m1_resp_valid && m1_resp_ready)) begin
                    if (exp_resp_q.size() > 0) check("rand_resp_data", m1_resp_valid ? m1_resp : m0_resp,
                                                     exp_resp_q.pop_front());
                    clr_busy = 1;
                    n_done++;
                end
            end
            if (set_busy) mbusy = 1;
            if (clr_busy) mbusy = 0;
            @(posedge clk);
            #1;
        end
        check("rand_drained", {mbusy, pend0, pend1, ds_has}, 0);
        check("rand_queues_empty", exp_q.size() + exp_resp_q.size(), 0);
        check("rand_progress", (n_done > 40) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmi_arbiter.md
DMI_ARBITER -- requirements
Module: dmi_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, response watchdog limit in clk_i cycles; legal range 1..65535.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 m0_req_i  input  dmi_req_t  master 0 request (addr, op, data).
REQ-005 m0_valid_i / m0_ready_o  input / output  1 / 1  master 0 request handshake.
REQ-006 m0_resp_o  output  dmi_resp_t  master 0 response (data, resp).
REQ-007 m0_resp_valid_o / m0_resp_ready_i  output / input  1 / 1  master 0 response handshake.
REQ-008 m1_* ports, identical to REQ-004..REQ-007 for master 1.
REQ-009 dmi_req_o  output  dmi_req_t  request toward the clock-crossing DMI port.
REQ-010 dmi_req_valid_o / dmi_req_ready_i  output / input  1 / 1  downstream request handshake.
REQ-011 dmi_resp_i  input  dmi_resp_t  downstream response.
REQ-012 dmi_resp_valid_i / dmi_resp_ready_o  input / output  1 / 1  downstream response handshake.
REQ-013 busy_o  output  1  high in any state other than IDLE.
REQ-014 owner_o  output  1  index of the current or most recent grantee.

Function
REQ-015 The FSM SHALL have four states: IDLE, REQ, RESP and DELIV. At most one transaction SHALL be outstanding.
REQ-016 IDLE behaviour:
- Grant SHALL go to a single valid master.
- If both masters are valid, grant SHALL go to the master not granted last (round-robin).
- The grantee's mX_ready_o SHALL be driven combinationally high.
- The request SHALL be captured into a register, owner SHALL be recorded, and the FSM SHALL move to REQ.
REQ-017 The non-granted master's ready SHALL stay low. All mX_ready_o SHALL be low outside IDLE.
REQ-018 In REQ, dmi_req_valid_o SHALL be 1 with dmi_req_o taken from the register. The first assertion SHALL be in the cycle after acceptance.
REQ-019 dmi_req_o SHALL stay stable until dmi_req_ready_i is seen. On ready the FSM SHALL move to RESP and clear the watchdog counter.
REQ-020 dmi_resp_ready_o SHALL be 1 in RESP and IDLE, and 0 in REQ and DELIV.
REQ-021 In RESP, when dmi_resp_valid_i is high, dmi_resp_i SHALL be registered and the FSM SHALL move to DELIV.
REQ-022 In DELIV, the owner's mX_resp_valid_o SHALL be 1 with the registered response held stable.
REQ-023 On the owner's mX_resp_ready_i, the FSM SHALL return to IDLE. The next grant SHALL be possible no earlier than the following cycle.
REQ-024 A response arriving in IDLE (stray) SHALL be accepted and discarded with no master-side effect.
REQ-025 The non-owner's resp_valid SHALL always be 0. The mX_resp_o of both masters SHALL show the response register.
REQ-026 Minimum transaction latency, with all readies tied high: accept to owner resp_valid SHALL be 3 cycles (accept in N, dmi_req_valid in N+1, resp captured at N+2 edge, DELIV in N+3 when the downstream responds in N+2).

Reset
REQ-027 While rst_i is high at a clock edge, the block SHALL enter IDLE and outputs SHALL become:
- all valid and ready outputs 0;
- busy_o = 0, owner_o = 0;
- request and response registers cleared to 0;
- last-grant set so that master 0 wins the first contention;
- watchdog counter = 0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction with no response delivered. A downstream response arriving after reset SHALL be handled as stray (REQ-024).

Configuration
REQ-029 The macro DMI_ARBITER_TIMEOUT_EN SHALL compile the response watchdog in or out.
REQ-030 With the macro defined, a 16-bit counter SHALL increment each cycle in RESP.
- If it reaches TIMEOUT_CYCLES-1 without dmi_resp_valid_i, the FSM SHALL load the response register with data = 0 and resp = 2'h2 (failed), then move to DELIV.
- If dmi_resp_valid_i arrives in the same cycle as expiry, the real response SHALL be taken.
- The late real response SHALL later be discarded as stray.
REQ-031 Without the macro, no counter SHALL exist and RESP SHALL wait indefinitely.

Verification
REQ-032 Single read:
- Stimulus: m0 sends addr 0x11, op 1; downstream ready immediately and returns data 0xDEADBEEF, resp 0 in the next cycle.
- Required: m0 sees 0xDEADBEEF; m1 resp_valid stays 0; latency is 3 cycles.
REQ-033 Contention:
- Stimulus: after reset, m0 and m1 hold valid continuously for 4 transactions.
- Required: grant order m0, m1, m0, m1; owner_o matches each grant.
REQ-034 Back-pressure:
- Stimulus: dmi_req_ready_i held low for 5 cycles; then m1_resp_ready_i held low for 3 cycles.
- Required: dmi_req_o stable throughout; mX_ready_o low; resp held stable; busy_o = 1 throughout.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES = 8):
- Stimulus: no downstream response; a response of 0x1234 arrives 20 cycles later.
- Required: owner gets resp 2'h2, data 0; the late response is consumed in IDLE and not forwarded.
REQ-036 Reset in RESP:
- Stimulus: rst_i pulsed while in RESP, then a response arrives.
- Required: all outputs return to reset values; the response is discarded; the next m0 request completes normally.
